// File: rtl/head_shift_sched_pkg.sv
// Shared parser definitions: shift widths, candidate limits and the shift-command struct.
// The width/limit macros may be overridden on the command line before this file is read.
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 4
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 3
`endif
`ifndef HEAD_CANDI_NUM
`define HEAD_CANDI_NUM 8
`endif
`ifndef META_CANDI_NUM
`define META_CANDI_NUM 4
`endif

package head_shift_sched_pkg;

  localparam int unsigned HeadShiftW   = `HEAD_SHIFT_WIDTH;
  localparam int unsigned MetaShiftW   = `META_SHIFT_WIDTH;
  localparam int unsigned HeadCandiNum = `HEAD_CANDI_NUM;
  localparam int unsigned MetaCandiNum = `META_CANDI_NUM;

  localparam logic [HeadShiftW-1:0] HeadShiftMax = HeadShiftW'(HeadCandiNum);
  localparam logic [MetaShiftW-1:0] MetaShiftMax = MetaShiftW'(MetaCandiNum);

  typedef struct packed {
    logic [HeadShiftW-1:0] head_shift;
    logic [MetaShiftW-1:0] meta_shift;
  } shift_cmd_t;

  typedef enum logic {StIdle, StPkt} sched_state_e;

  function automatic logic cmd_out_of_range(input shift_cmd_t cmd);
    return (cmd.head_shift > HeadShiftMax) || (cmd.meta_shift > MetaShiftMax);
  endfunction

  // Only the offending field is zeroed; an in-range sibling field is kept.
  function automatic shift_cmd_t clamp_cmd(input shift_cmd_t cmd);
    shift_cmd_t res;
    res = cmd;
    if (cmd.head_shift > HeadShiftMax) res.head_shift = '0;
    if (cmd.meta_shift > MetaShiftMax) res.meta_shift = '0;
    return res;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous shift-command FIFO with full/empty/count; read data is the current head.
module shift_cmd_fifo
  import head_shift_sched_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  shift_cmd_t      wdata_i,
  input  logic            pop_i,
  output shift_cmd_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  shift_cmd_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  always_comb begin
    full_o   = (count_q == CntW'(Depth));
    empty_o  = (count_q == '0);
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap naturally at their width.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/head_shift_sched.sv
// Schedules queued head/meta shift commands onto packet start slices with zero latency.
// Optional packet/miss statistics counters are enabled by defining SHIFT_SCHED_STATS_EN.
module head_shift_sched
  import head_shift_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [`HEAD_SHIFT_WIDTH-1:0] i_cmd_headShift,
  input  logic [`META_SHIFT_WIDTH-1:0] i_cmd_metaShift,
  input  logic                         i_headStart,
  input  logic                         i_headValid,
  output logic [`HEAD_SHIFT_WIDTH-1:0] o_headShift,
  output logic [`META_SHIFT_WIDTH-1:0] o_metaShift,
  output logic                         o_busy,
  output logic                         o_cmdMiss,
  output logic                         o_cmdErr
`ifdef SHIFT_SCHED_STATS_EN
  ,
  output logic [31:0]                  o_pktCnt,
  output logic [31:0]                  o_missCnt
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e    state_q, state_d;
  logic            miss_q, miss_d, err_q, err_d;
  shift_cmd_t      in_cmd, in_cmd_clamped, head_cmd, out_cmd;
  logic            fifo_full, fifo_empty, cmd_fire, bypass, push, pop;
  logic [CntW-1:0] fifo_cnt;
  logic            unused_cnt;

  assign unused_cnt = ^fifo_cnt;

  shift_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .wdata_i (in_cmd_clamped),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    in_cmd.head_shift = i_cmd_headShift;
    in_cmd.meta_shift = i_cmd_metaShift;
    in_cmd_clamped    = clamp_cmd(in_cmd);
    o_cmd_ready       = ~fifo_full;
    cmd_fire          = i_cmd_valid & ~fifo_full;
    // A command meeting a start slice on an empty FIFO is used directly, never stored.
    bypass            = cmd_fire & fifo_empty & i_headStart;
    push              = cmd_fire & ~bypass;
    pop               = i_headStart & ~fifo_empty;
    out_cmd           = '0;
    if (i_headStart) begin
      if (!fifo_empty)  out_cmd = head_cmd;
      else if (bypass)  out_cmd = in_cmd_clamped;
    end
    miss_d = i_headStart & fifo_empty & ~bypass;
    err_d  = cmd_fire & cmd_out_of_range(in_cmd);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_headStart) state_d = StPkt;
      StPkt:   if (!i_headStart && !i_headValid) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    o_headShift = out_cmd.head_shift;
    o_metaShift = out_cmd.meta_shift;
    o_busy      = (state_q == StPkt);
    o_cmdMiss   = miss_q;
    o_cmdErr    = err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

`ifdef SHIFT_SCHED_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (i_headStart && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (miss_d && miss_cnt_q != '1)     miss_cnt_d = miss_cnt_q + 32'd1;
    o_pktCnt  = pkt_cnt_q;
    o_missCnt = miss_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_head_shift_sched.sv
// Directed self-checking bench for head_shift_sched (FIFO_DEPTH = 4).
module tb_head_shift_sched;
  import head_shift_sched_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [HeadShiftW-1:0] i_cmd_headShift;
  logic [MetaShiftW-1:0] i_cmd_metaShift;
  logic                  i_headStart;
  logic                  i_headValid;
  logic [HeadShiftW-1:0] o_headShift;
  logic [MetaShiftW-1:0] o_metaShift;
  logic                  o_busy;
  logic                  o_cmdMiss;
  logic                  o_cmdErr;
`ifdef SHIFT_SCHED_STATS_EN
  logic [31:0]           o_pktCnt;
  logic [31:0]           o_missCnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;

  head_shift_sched #(
    .FIFO_DEPTH (4)
  ) u_dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_headShift (i_cmd_headShift),
    .i_cmd_metaShift (i_cmd_metaShift),
    .i_headStart     (i_headStart),
    .i_headValid     (i_headValid),
    .o_headShift     (o_headShift),
    .o_metaShift     (o_metaShift),
    .o_busy          (o_busy),
    .o_cmdMiss       (o_cmdMiss),
    .o_cmdErr        (o_cmdErr)
`ifdef SHIFT_SCHED_STATS_EN
    ,
    .o_pktCnt        (o_pktCnt),
    .o_missCnt       (o_missCnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int unsigned h, input int unsigned m);
    check_eq({tag, "_head"}, 32'(o_headShift), h);
    check_eq({tag, "_meta"}, 32'(o_metaShift), m);
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input int unsigned h, input int unsigned m);
    i_cmd_valid     = v;
    i_cmd_headShift = HeadShiftW'(h);
    i_cmd_metaShift = MetaShiftW'(m);
  endtask

  int unsigned exp_h [4] = '{2, 3, 4, 6};
  int unsigned exp_m [4] = '{2, 3, 4, 0};

  initial begin
    i_rst_n     = 1'b0;
    i_headStart = 1'b0;
    i_headValid = 1'b0;
    set_cmd(1'b0, 0, 0);
    #12;
    check_eq("rst_ready", 32'(o_cmd_ready), 1);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_miss", 32'(o_cmdMiss), 0);
    check_eq("rst_err", 32'(o_cmdErr), 0);
    check_out("rst_out", 0, 0);
    i_rst_n = 1'b1;
    cycle();

    // Queued command is presented on the start slice.
    set_cmd(1'b1, 3, 2);
    cycle();
    set_cmd(1'b0, 0, 0);
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("pop_3_2", 3, 2);
    check_eq("pop_busy_before", 32'(o_busy), 0);
    cycle();
    i_headStart = 1'b0;
    #1;
    check_out("no_start", 0, 0);
    check_eq("pkt_busy", 32'(o_busy), 1);
    i_headValid = 1'b0;
    cycle();
    check_eq("pkt_end_busy", 32'(o_busy), 0);

    // Bypass, then back-to-back start on empty FIFO gives a miss.
    set_cmd(1'b1, 5, 1);
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("bypass_5_1", 5, 1);
    cycle();
    set_cmd(1'b0, 0, 0);
    check_eq("bypass_nomiss", 32'(o_cmdMiss), 0);
    check_eq("bypass_noerr", 32'(o_cmdErr), 0);
    #1;
    check_out("miss_out", 0, 0);
    cycle();
    check_eq("miss_pulse", 32'(o_cmdMiss), 1);
    check_eq("b2b_busy", 32'(o_busy), 1);
    i_headStart = 1'b0;
    cycle();
    check_eq("miss_clear", 32'(o_cmdMiss), 0);
`ifdef SHIFT_SCHED_STATS_EN
    check_eq("pkt_cnt", o_pktCnt, 3);
    check_eq("miss_cnt", o_missCnt, 1);
`endif
    i_headValid = 1'b0;
    cycle();

    // Fill to depth, hold a 5th, then drain in order.
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, i + 1, i + 1);
      cycle();
    end
    check_eq("full_ready", 32'(o_cmd_ready), 0);
    set_cmd(1'b1, 6, 0);
    #1;
    check_out("full_no_start", 0, 0);
    cycle();
    check_eq("full_held", 32'(o_cmd_ready), 0);
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("full_pop", 1, 1);
    check_eq("full_pop_ready", 32'(o_cmd_ready), 0);
    cycle();
    check_eq("after_pop_ready", 32'(o_cmd_ready), 1);
    i_headStart = 1'b0;
    cycle();
    set_cmd(1'b0, 0, 0);
    check_eq("refill_ready", 32'(o_cmd_ready), 0);
    i_headStart = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_out($sformatf("order%0d", k), exp_h[k], exp_m[k]);
      cycle();
    end
    i_headStart = 1'b0;
    check_eq("drained_ready", 32'(o_cmd_ready), 1);
    i_headValid = 1'b0;
    cycle();

    // Out-of-range fields are clamped to 0; exact limits are accepted.
    set_cmd(1'b1, HeadCandiNum + 1, 1);
    cycle();
    check_eq("err_head", 32'(o_cmdErr), 1);
    set_cmd(1'b1, 2, MetaCandiNum + 1);
    cycle();
    check_eq("err_meta", 32'(o_cmdErr), 1);
    set_cmd(1'b1, HeadCandiNum, MetaCandiNum);
    cycle();
    check_eq("err_limit", 32'(o_cmdErr), 0);
    set_cmd(1'b0, 0, 0);
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("clamp_head", 0, 1);
    cycle();
    #1;
    check_out("clamp_meta", 2, 0);
    cycle();
    #1;
    check_out("limit_ok", HeadCandiNum, MetaCandiNum);
    cycle();
    i_headStart = 1'b0;
    i_headValid = 1'b0;
    cycle();

    // Reset mid-packet with two commands still queued.
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, i + 1, 0);
      cycle();
    end
    set_cmd(1'b0, 0, 0);
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("rst_pre_pop", 1, 0);
    cycle();
    i_headStart = 1'b0;
    #1;
    check_eq("rst_pre_busy", 32'(o_busy), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(o_busy), 0);
    check_eq("midrst_ready", 32'(o_cmd_ready), 1);
    cycle();
    i_rst_n     = 1'b1;
    i_headValid = 1'b0;
    cycle();
    i_headStart = 1'b1;
    i_headValid = 1'b1;
    #1;
    check_out("post_rst_out", 0, 0);
    cycle();
    check_eq("post_rst_miss", 32'(o_cmdMiss), 1);
    i_headStart = 1'b0;
    i_headValid = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/head_shift_sched.md
HEAD_SHIFT_SCHED -- requirements
Module: head_shift_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued shift commands (power of 2, >=2).
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  shift command offered by parser lookup
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_headShift  in  `HEAD_SHIFT_WIDTH  head discard amount in slices (0 = no shift)
- i_cmd_metaShift  in  `META_SHIFT_WIDTH  meta shift amount (0 = no shift)
- i_headStart  in  1  TAG_START_BIT of slice entering the shifter
- i_headValid  in  1  TAG_VALID_BIT of slice entering the shifter
- o_headShift  out  `HEAD_SHIFT_WIDTH  to shifter i_headShift
- o_metaShift  out  `META_SHIFT_WIDTH  to shifter i_metaShift
- o_busy  out  1  packet in flight
- o_cmdMiss  out  1  pulse: packet started with no command
- o_cmdErr  out  1  pulse: out-of-range command clamped

Function
REQ-003 SHALL queue commands in a FIFO_DEPTH-entry FIFO; o_cmd_ready = !full, from registered state only; no push while full even if a pop occurs that cycle.
REQ-004 SHALL pop exactly one command on every cycle with i_headStart=1; o_headShift/o_metaShift SHALL combinationally present the FIFO head in that same cycle (zero latency, so the shifter captures it with the start slice).
REQ-005 SHALL bypass the FIFO when empty and i_cmd_valid&i_headStart coincide: the incoming command drives the outputs directly and is not stored.
REQ-006 SHALL drive o_headShift=0 and o_metaShift=0 when i_headStart=1 with FIFO empty and no bypass; o_cmdMiss SHALL pulse 1 cycle later.
REQ-007 SHALL treat head shift > `HEAD_CANDI_NUM or meta shift > `META_CANDI_NUM as out of range: store the field as 0 and pulse o_cmdErr the cycle after the push.
REQ-008 SHALL drive o_headShift/o_metaShift=0 in any cycle without i_headStart.
REQ-009 SHALL implement FSM IDLE/PKT: IDLE->PKT on i_headStart; PKT->IDLE when i_headValid=0 and i_headStart=0; PKT with i_headStart stays PKT and pops (back-to-back packets); o_busy = (state==PKT).
REQ-010 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-011 SHALL, on i_rst_n=0 at any time incl. mid-packet, flush the FIFO, enter IDLE, and drive o_cmd_ready=1, o_busy=0, o_cmdMiss=0, o_cmdErr=0, shift outputs 0, counters 0.

Configuration
REQ-012 SHALL, when SHIFT_SCHED_STATS_EN is defined, add outputs o_pktCnt[31:0] (increments per i_headStart) and o_missCnt[31:0] (increments per miss), both saturating at 2^32-1; without it these ports and counters SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-013 SHALL take `HEAD_SHIFT_WIDTH, `META_SHIFT_WIDTH, `HEAD_CANDI_NUM, `META_CANDI_NUM from the shared parser definitions package; a shift-command struct {headShift, metaShift} SHALL be added there.
REQ-014 SHALL instantiate one sub-module, shift_cmd_fifo (synchronous FIFO with full/empty/count).

Verification
REQ-015 Push cmd(3,2), then i_headStart -> outputs 3/2 in that cycle, FIFO empty after, o_busy=1 next cycle.
REQ-016 Empty FIFO, i_cmd_valid with (5,1) and i_headStart same cycle -> outputs 5/1, FIFO count stays 0.
REQ-017 i_headStart with FIFO empty, no valid -> outputs 0/0, o_cmdMiss=1 next cycle (o_missCnt=1 with STATS_EN).
REQ-018 Push 4 commands (depth 4) -> o_cmd_ready=0; 5th held; start slice pops first, ready=1 next cycle; order preserved.
REQ-019 Push head shift `HEAD_CANDI_NUM+1 -> o_cmdErr pulse, later pop yields head shift 0.
REQ-020 Assert i_rst_n=0 mid-packet with 2 queued -> o_busy=0, o_cmd_ready=1, next start reports miss.
